// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_stage
// Description : MIPS execute stage plus EX/MEM pipeline register.
//               Forwarding muxes, ALU, branch resolution and a 32-iteration
//               shift-add multiplier that stalls the front of the pipeline.
// Ports       : clk, rst_n (async, active low), clr (sync flush)
//               ID/EX control : RFWEE MtoRFSelE DMWEE BranchE ALUInSelE
//                               RFDSelE ALUSelE[3:0]
//               ID/EX data    : ALUIn1E DMdInE SImmE PCp1E [31:0], rtE rdE [4:0]
//               Hazard unit   : ForwardAE ForwardBE [1:0], ResultW [31:0]
//               Outputs       : StallE PCSrcE PCBranchE[31:0]
//                               RFWEM MtoRFSelM DMWEM ALUOutM DMdInM RFAM
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        RFWEE,
  input  logic        MtoRFSelE,
  input  logic        DMWEE,
  input  logic        BranchE,
  input  logic        ALUInSelE,
  input  logic        RFDSelE,
  input  logic [3:0]  ALUSelE,
  input  logic [31:0] ALUIn1E,
  input  logic [31:0] DMdInE,
  input  logic [31:0] SImmE,
  input  logic [31:0] PCp1E,
  input  logic [4:0]  rtE,
  input  logic [4:0]  rdE,
  input  logic [1:0]  ForwardAE,
  input  logic [1:0]  ForwardBE,
  input  logic [31:0] ResultW,
  output logic        StallE,
  output logic        PCSrcE,
  output logic [31:0] PCBranchE,
  output logic        RFWEM,
  output logic        MtoRFSelM,
  output logic        DMWEM,
  output logic [31:0] ALUOutM,
  output logic [31:0] DMdInM,
  output logic [4:0]  RFAM
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_MUL = 4'b1000;
  localparam logic [3:0] OP_NOR = 4'b1100;

  logic [1:0]  r_state;
  logic [31:0] r_mcand;
  logic [31:0] r_mplier;
  logic [31:0] r_acc;
  logic [4:0]  r_cnt;

  logic [31:0] w_srcA;
  logic [31:0] w_fwdB;
  logic [31:0] w_srcB;
  logic [31:0] w_alu;
  logic [31:0] w_result;
  logic [31:0] w_addend;
  logic        w_launch;
  logic [4:0]  w_dest;

  // Forwarding: 10 = MEM-stage ALU result, 01 = write-back value, else register.
  always_comb begin
    case (ForwardAE)
      2'b10:   w_srcA = ALUOutM;
      2'b01:   w_srcA = ResultW;
      default: w_srcA = ALUIn1E;
    endcase
    case (ForwardBE)
      2'b10:   w_fwdB = ALUOutM;
      2'b01:   w_fwdB = ResultW;
      default: w_fwdB = DMdInE;
    endcase
  end

  assign w_srcB = ALUInSelE ? SImmE : w_fwdB;

  // Single-cycle ALU; MUL yields 0 here because its result comes from r_acc.
  always_comb begin
    case (ALUSelE)
      OP_AND:  w_alu = w_srcA & w_srcB;
      OP_OR:   w_alu = w_srcA | w_srcB;
      OP_ADD:  w_alu = w_srcA + w_srcB;
      OP_SUB:  w_alu = w_srcA - w_srcB;
      OP_SLT:  w_alu = {31'b0, ($signed(w_srcA) < $signed(w_srcB))};
      OP_NOR:  w_alu = ~(w_srcA | w_srcB);
      OP_XOR:  w_alu = w_srcA ^ w_srcB;
      OP_SLL:  w_alu = w_srcB << SImmE[10:6];
      default: w_alu = 32'b0;
    endcase
  end

  // In DONE the held MUL instruction is still on the inputs; its result is the
  // accumulated product.
  assign w_result  = (r_state == S_DONE) ? r_acc : w_alu;
  assign PCSrcE    = BranchE & (w_result == 32'b0);
  assign PCBranchE = PCp1E + SImmE;

  assign w_launch  = (r_state == S_IDLE) && (ALUSelE == OP_MUL) && !clr;
  assign StallE    = w_launch || (r_state == S_BUSY);
  assign w_addend  = r_mplier[0] ? r_mcand : 32'b0;
  assign w_dest    = RFDSelE ? rdE : rtE;

  // Shift-add multiplier. Operands are sampled once at launch, so forwarded
  // values changing during BUSY have no effect on the product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_mcand  <= 32'b0;
      r_mplier <= 32'b0;
      r_acc    <= 32'b0;
      r_cnt    <= 5'b0;
    end else if (clr) begin
      r_state <= S_IDLE;
      r_acc   <= 32'b0;
      r_cnt   <= 5'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_mcand  <= w_srcA;
            r_mplier <= w_srcB;
            r_acc    <= 32'b0;
            r_cnt    <= 5'b0;
            r_state  <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_acc    <= r_acc + w_addend;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // EX/MEM register: a stall or flush inserts a fully zeroed bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RFWEM     <= 1'b0;
      MtoRFSelM <= 1'b0;
      DMWEM     <= 1'b0;
      ALUOutM   <= 32'b0;
      DMdInM    <= 32'b0;
      RFAM      <= 5'b0;
    end else if (clr || StallE) begin
      RFWEM     <= 1'b0;
      MtoRFSelM <= 1'b0;
      DMWEM     <= 1'b0;
      ALUOutM   <= 32'b0;
      DMdInM    <= 32'b0;
      RFAM      <= 5'b0;
    end else begin
      RFWEM     <= RFWEE;
      MtoRFSelM <= MtoRFSelE;
      DMWEM     <= DMWEE;
      ALUOutM   <= w_result;
      DMdInM    <= w_fwdB;
      RFAM      <= w_dest;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_mem_stage
// Description : Self-checking bench for ex_mem_stage with a behavioural model
//               of the execute stage and EX/MEM register.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic        RFWEE, MtoRFSelE, DMWEE, BranchE, ALUInSelE, RFDSelE;
  logic [3:0]  ALUSelE;
  logic [31:0] ALUIn1E, DMdInE, SImmE, PCp1E, ResultW;
  logic [4:0]  rtE, rdE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        StallE, PCSrcE, RFWEM, MtoRFSelM, DMWEM;
  logic [31:0] PCBranchE, ALUOutM, DMdInM;
  logic [4:0]  RFAM;

  int n_tests = 0;
  int n_fail  = 0;

  // Model of the EX/MEM register contents
  logic        m_rfwe, m_mtorf, m_dmwe;
  logic [31:0] m_alu, m_dmd;
  logic [4:0]  m_rfa;

  ex_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .RFWEE(RFWEE), .MtoRFSelE(MtoRFSelE), .DMWEE(DMWEE), .BranchE(BranchE),
    .ALUInSelE(ALUInSelE), .RFDSelE(RFDSelE), .ALUSelE(ALUSelE),
    .ALUIn1E(ALUIn1E), .DMdInE(DMdInE), .SImmE(SImmE), .PCp1E(PCp1E),
    .rtE(rtE), .rdE(rdE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW), .StallE(StallE), .PCSrcE(PCSrcE), .PCBranchE(PCBranchE),
    .RFWEM(RFWEM), .MtoRFSelM(MtoRFSelM), .DMWEM(DMWEM), .ALUOutM(ALUOutM),
    .DMdInM(DMdInM), .RFAM(RFAM)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] imm);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      4'b0011: return a ^ b;
      4'b0100: return b << imm[10:6];
      4'b1000: return a * b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rv,
                                      input logic [31:0] aluo, input logic [31:0] resw);
    if (sel == 2'b10) return aluo;
    if (sel == 2'b01) return resw;
    return rv;
  endfunction

  task automatic model_bubble();
    m_rfwe = 0; m_mtorf = 0; m_dmwe = 0; m_alu = 0; m_dmd = 0; m_rfa = 0;
  endtask

  task automatic check_m(input string tag);
    chk({tag, "_RFWEM"},     32'(RFWEM),     32'(m_rfwe));
    chk({tag, "_MtoRFSelM"}, 32'(MtoRFSelM), 32'(m_mtorf));
    chk({tag, "_DMWEM"},     32'(DMWEM),     32'(m_dmwe));
    chk({tag, "_ALUOutM"},   ALUOutM,        m_alu);
    chk({tag, "_DMdInM"},    DMdInM,         m_dmd);
    chk({tag, "_RFAM"},      32'(RFAM),      32'(m_rfa));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    clr = 0; RFWEE = 0; MtoRFSelE = 0; DMWEE = 0; BranchE = 0; ALUInSelE = 0;
    RFDSelE = 0; ALUSelE = 4'b0000; ALUIn1E = 0; DMdInE = 0; SImmE = 0;
    PCp1E = 0; rtE = 0; rdE = 0; ForwardAE = 0; ForwardBE = 0; ResultW = 0;
  endtask

  // One non-MUL instruction through E: combinational checks, one edge, M checks.
  task automatic do_single(input string tag);
    logic [31:0] a, fb, b, r;
    a  = fwd(ForwardAE, ALUIn1E, m_alu, ResultW);
    fb = fwd(ForwardBE, DMdInE, m_alu, ResultW);
    b  = ALUInSelE ? SImmE : fb;
    r  = ref_alu(ALUSelE, a, b, SImmE);
    #1;
    chk({tag, "_StallE"},    32'(StallE), 32'd0);
    chk({tag, "_PCSrcE"},    32'(PCSrcE), 32'(BranchE && (r == 0)));
    chk({tag, "_PCBranchE"}, PCBranchE,   PCp1E + SImmE);
    step();
    if (clr) model_bubble();
    else begin
      m_rfwe = RFWEE; m_mtorf = MtoRFSelE; m_dmwe = DMWEE;
      m_alu = r; m_dmd = fb; m_rfa = RFDSelE ? rdE : rtE;
    end
    check_m(tag);
  endtask

  // A full MUL: 33 stall cycles with bubbles, then the DONE cycle captures it.
  task automatic do_mul(input string tag);
    logic [31:0] a, b, prod, fb;
    a    = fwd(ForwardAE, ALUIn1E, m_alu, ResultW);
    b    = ALUInSelE ? SImmE : fwd(ForwardBE, DMdInE, m_alu, ResultW);
    prod = a * b;
    for (int i = 0; i < 33; i++) begin
      #1;
      chk({tag, "_stall"}, 32'(StallE), 32'd1);
      step();
      model_bubble();
      chk({tag, "_bubble_ALUOutM"}, ALUOutM,     32'd0);
      chk({tag, "_bubble_RFWEM"},   32'(RFWEM),  32'd0);
      ResultW = $urandom;  // must not disturb the product
    end
    fb = fwd(ForwardBE, DMdInE, m_alu, ResultW);
    #1;
    chk({tag, "_done_stall"}, 32'(StallE), 32'd0);
    step();
    m_rfwe = RFWEE; m_mtorf = MtoRFSelE; m_dmwe = DMWEE;
    m_alu = prod; m_dmd = fb; m_rfa = RFDSelE ? rdE : rtE;
    check_m(tag);
  endtask

  task automatic rand_fields();
    logic [3:0] ops [11];
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100,
            4'b0011, 4'b0100, 4'b0101, 4'b1001, 4'b1111};
    clr = 0;
    RFWEE = 1'($urandom); MtoRFSelE = 1'($urandom); DMWEE = 1'($urandom);
    BranchE = 1'($urandom); ALUInSelE = 1'($urandom); RFDSelE = 1'($urandom);
    ALUSelE = ops[$urandom_range(0, 10)];
    ALUIn1E = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20));
    DMdInE  = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20));
    SImmE = $urandom; PCp1E = $urandom; ResultW = $urandom;
    rtE = 5'($urandom); rdE = 5'($urandom);
    ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
    if ($urandom_range(0, 3) == 0) begin
      DMdInE = ALUIn1E; ForwardAE = 0; ForwardBE = 0; ALUInSelE = 0;
    end
  endtask

  initial begin
    clear_inputs();
    model_bubble();
    rst_n = 0;
    #1;
    chk("reset_StallE", 32'(StallE), 32'd0);
    check_m("reset");
    step();
    step();
    #2 rst_n = 1;
    step();

    // ADD 5+7 -> rd 9
    clear_inputs();
    ALUIn1E = 5; DMdInE = 7; ALUSelE = 4'b0010; RFDSelE = 1; rdE = 9; RFWEE = 1;
    do_single("add");
    chk("add_value", ALUOutM, 32'd12);

    // Produce ALUOutM=100, then forward it into a SUB with ResultW=3
    clear_inputs();
    ALUIn1E = 60; DMdInE = 40; ALUSelE = 4'b0010; RFWEE = 1;
    do_single("add100");
    clear_inputs();
    ALUIn1E = 1; DMdInE = 2; ALUSelE = 4'b0110; ForwardAE = 2'b10;
    ForwardBE = 2'b01; ResultW = 3; RFWEE = 1;
    do_single("fwd_sub");
    chk("fwd_sub_value", ALUOutM, 32'd97);
    chk("fwd_sub_store", DMdInM, 32'd3);

    // BEQ taken and not taken
    clear_inputs();
    ALUIn1E = 4; DMdInE = 4; ALUSelE = 4'b0110; BranchE = 1;
    PCp1E = 32'h10; SImmE = 32'hFFFFFFFC;
    #1;
    chk("beq_taken", 32'(PCSrcE), 32'd1);
    chk("beq_target", PCBranchE, 32'h0C);
    do_single("beq_taken");
    clear_inputs();
    ALUIn1E = 4; DMdInE = 5; ALUSelE = 4'b0110; BranchE = 1;
    #1;
    chk("beq_not_taken", 32'(PCSrcE), 32'd0);
    do_single("beq_nt");

    // Directed MULs, back to back
    clear_inputs();
    ALUSelE = 4'b1000; ALUIn1E = 6; DMdInE = 7; RFWEE = 1; rtE = 5;
    do_mul("mul_6x7");
    chk("mul_6x7_value", ALUOutM, 32'd42);
    ALUIn1E = 32'hFFFFFFFF; DMdInE = 2;
    do_mul("mul_ffff_x2");
    chk("mul_ffff_value", ALUOutM, 32'hFFFFFFFE);
    ALUIn1E = 32'h10000; DMdInE = 32'h10000;
    do_mul("mul_wrap");
    chk("mul_wrap_value", ALUOutM, 32'd0);

    // clr with MUL present in IDLE: no launch, bubble
    clear_inputs();
    ALUSelE = 4'b1000; ALUIn1E = 3; DMdInE = 3; RFWEE = 1; clr = 1;
    do_single("clr_idle");

    // clr in BUSY cycle 10 aborts the MUL
    clear_inputs();
    ALUSelE = 4'b1000; ALUIn1E = 5; DMdInE = 5; RFWEE = 1;
    for (int i = 0; i < 11; i++) step();
    clr = 1;
    step();
    model_bubble();
    check_m("clr_busy");
    clear_inputs();
    ALUIn1E = 1; DMdInE = 1; ALUSelE = 4'b0010; RFWEE = 1;
    do_single("after_clr");
    do_single("after_clr2");

    // Reset with valid M contents clears them immediately
    #2 rst_n = 0;
    #1;
    model_bubble();
    check_m("async_reset");
    step();
    #2 rst_n = 1;
    step();

    // Reset at BUSY cycle 20
    clear_inputs();
    ALUSelE = 4'b1000; ALUIn1E = 7; DMdInE = 7; RFWEE = 1;
    for (int i = 0; i < 21; i++) step();
    #2 rst_n = 0;
    #1;
    check_m("reset_busy");
    chk("reset_busy_stall_mul_present", 32'(StallE), 32'd1);
    ALUSelE = 4'b0010;
    #1;
    chk("reset_busy_stall_removed", 32'(StallE), 32'd0);
    step();
    #2 rst_n = 1;
    step();
    clear_inputs();
    ALUSelE = 4'b1000; ALUIn1E = 3; DMdInE = 3; RFWEE = 1; rdE = 4; RFDSelE = 1;
    do_mul("mul_3x3");
    chk("mul_3x3_value", ALUOutM, 32'd9);

    // Randomized mix
    for (int k = 0; k < 150; k++) begin
      rand_fields();
      if ($urandom_range(0, 9) == 0) begin
        ALUSelE = 4'b1000; BranchE = 0;
        do_mul("rnd_mul");
      end else begin
        clr = ($urandom_range(0, 15) == 0);
        do_single("rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
